led_mode_controller: RTL and testbench
======================================

// Module: led_mode_controller
// PURPOSE
//  Board-level controller sequencing the four user LEDs from the four user switches.
//  Each switch is synchronised and debounced; a debounced release (1->0) is one event.
//  Mode FSM: TOGGLE (switch n toggles LED n) or CHASE (rotating single-LED pattern with pause/reverse).
//  Sits directly between the switch pins and the LED pins in the top level.
// PARAMETERS
//  DEBOUNCE_LIMIT  250000   consecutive stable cycles before a switch change is accepted (>=1)
//  CHASE_TICKS     2500000  clocks per chase step (>=2)
// PORTS
//  i_Clk              in   1  system clock
//  i_Reset            in   1  asynchronous, active-high reset
//  i_Switch_1..4      in   1  raw switch pins, 1 = pressed, asynchronous to i_Clk
//  o_LED_1..4         out  1  LED drives, 1 = on, registered
//  o_Mode             out  2  00 TOGGLE, 01 CHASE_RUN, 10 CHASE_HOLD, registered (11 unused)
// BEHAVIOUR
//  Reset (async assert, all state): sync flops 0, debounced state 0, counters 0, FSM TOGGLE,
//   direction up, LEDs 0000, o_Mode 00. Effective immediately, including mid-chase.
//  Filter per switch: 2-flop sync; counter cleared whenever sync out == stable value, else increments;
//   on DEBOUNCE_LIMIT-th consecutive mismatch cycle, stable <= sync out and counter clears.
//   Mismatch run shorter than DEBOUNCE_LIMIT: no change, no event.
//  Release event: registered 1-cycle pulse when stable goes 1->0. Press (0->1) produces no event.
//  Latency: LED/o_Mode update exactly DEBOUNCE_LIMIT+4 clocks after the first i_Clk edge sampling
//   the pin low (2 sync + DEBOUNCE_LIMIT filter + 1 pulse + 1 output reg).
//  FSM:
//   TOGGLE: rel1..3 toggle LED1..3 (several in one cycle all apply); LED4 held 0.
//           rel4 -> CHASE_RUN: LEDs 0001, tick counter 0, direction up; rel1..3 same cycle ignored.
//   CHASE_RUN: tick counter 0..CHASE_TICKS-1; on wrap to 0 pattern rotates one step:
//           up 0001->0010->0100->1000->0001, down the reverse (LED_1 is bit 0).
//           rel1 -> CHASE_HOLD. rel2 toggles direction (applies from next step). rel3 ignored.
//           rel4 -> TOGGLE, LEDs 0000, direction up; overrides rel1/rel2 same cycle.
//           Step and rel1 same cycle: step applied, then hold.
//   CHASE_HOLD: pattern and tick counter frozen. rel1 -> CHASE_RUN (counter resumes from frozen value).
//           rel2 toggles direction while held. rel4 -> TOGGLE as above (priority).
//  Exactly one LED on in both chase states; rel4 has priority over all other events in every state.
//  Widths: debounce counter $clog2(DEBOUNCE_LIMIT+1), tick counter $clog2(CHASE_TICKS); no overflow.
// STRUCTURE
//  Shared header led_ctrl_defs.vh: mode encodings (TOGGLE/CHASE_RUN/CHASE_HOLD), o_Mode values.
//  Sub-module debounce_filter (param DEBOUNCE_LIMIT; i_Clk, i_Reset, i_Raw -> o_Stable, o_Release),
//   instantiated 4x. FSM, tick counter, direction and LED register live in this module.
// TESTING  (bench overrides DEBOUNCE_LIMIT=4, CHASE_TICKS=8)
//  Toggle: sw1 high 10 clks then low -> LED1 rises exactly 8 clks after low sampled; repeat -> LED1 0.
//  Bounce: sw2 high 3 clks then low; also low-glitch of 3 clks while held -> no LED/mode change ever.
//  Chase: release sw4 -> o_Mode=01, LEDs 0001; then 0010,0100,1000,0001 every 8 clks (wrap checked).
//  Hold/reverse: rel1 at 0100 -> o_Mode=10, frozen 30 clks; rel2 then rel1 -> 0010 then 0001 steps.
//  Priority: sw1+sw4 released same clk in TOGGLE -> o_Mode=01, LEDs 0001, no LED1 toggle.
//  Reset mid-chase: assert i_Reset between clk edges -> LEDs 0000, o_Mode 00 before next edge.

Source files
------------

// File: rtl/led_mode_controller_pkg.sv
// -----------------------------------------------------------------------------
// led_mode_controller_pkg
//   Shared definitions for the LED mode controller:
//   - o_Mode / FSM state encodings (TOGGLE, CHASE_RUN, CHASE_HOLD)
//   - helper that advances the one-hot chase pattern by one step
// -----------------------------------------------------------------------------
package led_mode_controller_pkg;

    // Mode encodings double as the FSM state values and the o_Mode output.
    localparam logic [1:0] MODE_TOGGLE     = 2'b00;
    localparam logic [1:0] MODE_CHASE_RUN  = 2'b01;
    localparam logic [1:0] MODE_CHASE_HOLD = 2'b10;

    // Rotate the one-hot LED pattern one position; LED_1 is bit 0.
    // Up moves towards LED_4 (0001 -> 0010), down moves towards LED_1.
    function automatic logic [3:0] chase_rotate(input logic [3:0] leds,
                                                input logic       dir_up);
        logic [3:0] result;
        if (dir_up) begin
            result = {leds[2:0], leds[3]};
        end else begin
            result = {leds[0], leds[3:1]};
        end
        return result;
    endfunction

endpackage

// File: rtl/led_mode_controller_debounce_filter.sv
// -----------------------------------------------------------------------------
// debounce_filter
//   Two-flop synchroniser followed by a consecutive-mismatch debounce counter.
//   A change on the synchronised input is accepted only after DEBOUNCE_LIMIT
//   consecutive cycles of disagreement with the current stable value.
//   A release (stable 1->0) produces a registered one-cycle pulse one clock
//   after the stable value changes.
// Ports
//   i_Clk      in  1  system clock
//   i_Reset    in  1  asynchronous, active-high reset
//   i_Raw      in  1  raw switch pin (asynchronous to i_Clk)
//   o_Stable   out 1  debounced switch state
//   o_Release  out 1  one-cycle pulse on debounced release
// -----------------------------------------------------------------------------
module debounce_filter #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Raw,
    output logic o_Stable,
    output logic o_Release
);

    localparam int             CW       = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

    logic          sync1_q,       sync1_d;
    logic          sync2_q,       sync2_d;
    logic          stable_q,      stable_d;
    logic          stable_prev_q, stable_prev_d;
    logic          release_q,     release_d;
    logic [CW-1:0] cnt_q,         cnt_d;

    // Next-state logic for synchroniser, debounce counter and release pulse.
    always_comb begin
        sync1_d       = i_Raw;
        sync2_d       = sync1_q;
        stable_d      = stable_q;
        cnt_d         = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            // Last mismatch cycle of the run: accept the new level.
            stable_d = sync2_q;
            cnt_d    = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        // Pulse is taken from the registered stable value, adding one
        // clock so the event lands a full cycle after acceptance.
        stable_prev_d = stable_q;
        release_d     = stable_prev_q & ~stable_q;
    end

    // Filter state registers with asynchronous reset.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            release_q     <= 1'b0;
            cnt_q         <= {CW{1'b0}};
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            release_q     <= release_d;
            cnt_q         <= cnt_d;
        end
    end

    assign o_Stable  = stable_q;
    assign o_Release = release_q;

endmodule

// File: rtl/led_mode_controller.sv
// -----------------------------------------------------------------------------
// led_mode_controller
//   Drives the four user LEDs from the four user switches. Each switch is
//   debounced; a debounced release is one event. TOGGLE mode: release n
//   toggles LED n (n = 1..3). Release of switch 4 enters/leaves CHASE, where a
//   single lit LED rotates every CHASE_TICKS clocks; switch 1 pauses/resumes,
//   switch 2 reverses direction.
// Ports
//   i_Clk            in  1  system clock
//   i_Reset          in  1  asynchronous, active-high reset
//   i_Switch_1..4    in  1  raw switch pins, 1 = pressed
//   o_LED_1..4       out 1  LED drives, 1 = on, registered
//   o_Mode           out 2  00 TOGGLE, 01 CHASE_RUN, 10 CHASE_HOLD, registered
// -----------------------------------------------------------------------------
module led_mode_controller
    import led_mode_controller_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int CHASE_TICKS    = 2500000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    input  logic       i_Switch_3,
    input  logic       i_Switch_4,
    output logic       o_LED_1,
    output logic       o_LED_2,
    output logic       o_LED_3,
    output logic       o_LED_4,
    output logic [1:0] o_Mode
);

    localparam int            TW        = $clog2(CHASE_TICKS);
    localparam logic [TW-1:0] TICK_LAST = TW'(CHASE_TICKS - 1);

    logic [3:0]    raw_s;
    logic [3:0]    rel_s;
    logic [3:0]    stable_unused_s;

    logic [1:0]    mode_q,   mode_d;
    logic [3:0]    led_q,    led_d;
    logic [TW-1:0] tick_q,   tick_d;
    logic          dir_up_q, dir_up_d;

    assign raw_s = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    for (genvar g = 0; g < 4; g++) begin : g_filter
        debounce_filter #(
            .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT)
        ) u_filter (
            .i_Clk     (i_Clk),
            .i_Reset   (i_Reset),
            .i_Raw     (raw_s[g]),
            .o_Stable  (stable_unused_s[g]),
            .o_Release (rel_s[g])
        );
    end

    // Mode FSM, chase tick counter, direction and LED pattern next-state.
    always_comb begin
        mode_d   = mode_q;
        led_d    = led_q;
        tick_d   = tick_q;
        dir_up_d = dir_up_q;
        case (mode_q)
            MODE_TOGGLE: begin
                if (rel_s[3]) begin
                    // Switch 4 wins; releases on 1..3 in the same cycle are dropped.
                    mode_d   = MODE_CHASE_RUN;
                    led_d    = 4'b0001;
                    tick_d   = {TW{1'b0}};
                    dir_up_d = 1'b1;
                end else begin
                    led_d  = {1'b0, led_q[2:0] ^ rel_s[2:0]};
                    tick_d = {TW{1'b0}};
                end
            end
            MODE_CHASE_RUN: begin
                if (rel_s[3]) begin
                    mode_d   = MODE_TOGGLE;
                    led_d    = 4'b0000;
                    tick_d   = {TW{1'b0}};
                    dir_up_d = 1'b1;
                end else begin
                    // The step uses the current direction; a reversal in the
                    // same cycle only affects the following step.
                    if (tick_q == TICK_LAST) begin
                        tick_d = {TW{1'b0}};
                        led_d  = chase_rotate(led_q, dir_up_q);
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                    if (rel_s[1]) begin
                        dir_up_d = ~dir_up_q;
                    end else begin
                        dir_up_d = dir_up_q;
                    end
                    if (rel_s[0]) begin
                        mode_d = MODE_CHASE_HOLD;
                    end else begin
                        mode_d = MODE_CHASE_RUN;
                    end
                end
            end
            MODE_CHASE_HOLD: begin
                if (rel_s[3]) begin
                    mode_d   = MODE_TOGGLE;
                    led_d    = 4'b0000;
                    tick_d   = {TW{1'b0}};
                    dir_up_d = 1'b1;
                end else begin
                    // Pattern and tick count stay frozen until resumed.
                    if (rel_s[1]) begin
                        dir_up_d = ~dir_up_q;
                    end else begin
                        dir_up_d = dir_up_q;
                    end
                    if (rel_s[0]) begin
                        mode_d = MODE_CHASE_RUN;
                    end else begin
                        mode_d = MODE_CHASE_HOLD;
                    end
                end
            end
            default: begin
                // Unused encoding: recover to a clean TOGGLE state.
                mode_d   = MODE_TOGGLE;
                led_d    = 4'b0000;
                tick_d   = {TW{1'b0}};
                dir_up_d = 1'b1;
            end
        endcase
    end

    // Controller state registers with asynchronous reset.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            mode_q   <= MODE_TOGGLE;
            led_q    <= 4'b0000;
            tick_q   <= {TW{1'b0}};
            dir_up_q <= 1'b1;
        end else begin
            mode_q   <= mode_d;
            led_q    <= led_d;
            tick_q   <= tick_d;
            dir_up_q <= dir_up_d;
        end
    end

    assign o_LED_1 = led_q[0];
    assign o_LED_2 = led_q[1];
    assign o_LED_3 = led_q[2];
    assign o_LED_4 = led_q[3];
    assign o_Mode  = mode_q;

endmodule

// File: tb/tb_led_mode_controller.sv
// -----------------------------------------------------------------------------
// tb_led_mode_controller
//   Directed scenarios followed by random switch activity. Every clock edge the
//   DUT's {o_Mode, LED_4..LED_1} is compared with a behavioural model: each
//   switch's debounced level changes once the last DEBOUNCE_LIMIT pin samples
//   (seen two clocks late through the synchroniser) all disagree with it, and a
//   release acts on the mode/LED model two clocks after that. The chase
//   pattern is modelled as a lit position 0..3 with a step direction.
// -----------------------------------------------------------------------------
module tb_led_mode_controller;

    localparam int L  = 4;
    localparam int CT = 8;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic       led1, led2, led3, led4;
    logic [1:0] mode;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model state
    bit [L+1:0] hist [4];
    bit [3:0]   stable_m;
    bit [3:0]   rel1_m;
    bit [3:0]   rel2_m;
    logic [1:0] m_mode;
    int         pos;
    bit         dir_up;
    int         tick;
    bit [3:0]   tog;

    led_mode_controller #(
        .DEBOUNCE_LIMIT (L),
        .CHASE_TICKS    (CT)
    ) dut (
        .i_Clk      (clk),
        .i_Reset    (rst),
        .i_Switch_1 (sw[0]),
        .i_Switch_2 (sw[1]),
        .i_Switch_3 (sw[2]),
        .i_Switch_4 (sw[3]),
        .o_LED_1    (led1),
        .o_LED_2    (led2),
        .o_LED_3    (led3),
        .o_LED_4    (led4),
        .o_Mode     (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] obs();
        return {mode, led4, led3, led2, led1};
    endfunction

    function automatic logic [5:0] expv();
        logic [3:0] l;
        if (m_mode == 2'd0) l = tog;
        else                l = 4'b0001 << pos;
        return {m_mode, l};
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 4; s++) hist[s] = '0;
        stable_m = 4'b0000;
        rel1_m   = 4'b0000;
        rel2_m   = 4'b0000;
        m_mode   = 2'd0;
        pos      = 0;
        dir_up   = 1'b1;
        tick     = 0;
        tog      = 4'b0000;
    endfunction

    function automatic void to_toggle();
        m_mode = 2'd0;
        tog    = 4'b0000;
        dir_up = 1'b1;
        tick   = 0;
    endfunction

    // Advance the model by one clock edge with pin levels p sampled at it.
    function automatic void model_edge(input logic [3:0] p);
        bit [3:0]   r;
        bit [L-1:0] win;
        r = rel2_m;
        case (m_mode)
            2'd0: begin
                if (r[3]) begin
                    m_mode = 2'd1; pos = 0; tick = 0; dir_up = 1'b1;
                end else begin
                    tog = tog ^ {1'b0, r[2:0]};
                end
            end
            2'd1: begin
                if (r[3]) begin
                    to_toggle();
                end else begin
                    if (tick == CT - 1) begin
                        tick = 0;
                        pos  = dir_up ? (pos + 1) % 4 : (pos + 3) % 4;
                    end else begin
                        tick = tick + 1;
                    end
                    if (r[1]) dir_up = !dir_up;
                    if (r[0]) m_mode = 2'd2;
                end
            end
            2'd2: begin
                if (r[3]) begin
                    to_toggle();
                end else begin
                    if (r[1]) dir_up = !dir_up;
                    if (r[0]) m_mode = 2'd1;
                end
            end
            default: to_toggle();
        endcase
        rel2_m = rel1_m;
        rel1_m = 4'b0000;
        for (int s = 0; s < 4; s++) begin
            hist[s] = {hist[s][L:0], bit'(p[s])};
            win     = hist[s][L+1:2];
            if (stable_m[s] ? (win == '0) : (&win)) begin
                if (stable_m[s]) rel1_m[s] = 1'b1;
                stable_m[s] = ~stable_m[s];
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [5:0] o, input logic [5:0] e);
        n_total = n_total + 1;
        assert (o === e) n_pass = n_pass + 1;
        else $error("FAIL %s: mode/leds observed %b expected %b", tag, o, e);
    endtask

    // One clock edge: update model, then compare 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(sw);
        #1;
        chk("cycle", obs(), expv());
    endtask

    initial begin
        rst = 1'b1;
        sw  = 4'b0000;
        model_reset();
        repeat (3) step();
        #2 rst = 1'b0;
        chk("reset_state", obs(), 6'b00_0000);

        // Toggle LED1: the 8th edge counting the one that samples the pin low.
        sw[0] = 1'b1; repeat (10) step(); sw[0] = 1'b0;
        repeat (7) step();
        chk("tog_before_latency", obs(), 6'b00_0000);
        step();
        chk("tog_rise", obs(), 6'b00_0001);
        sw[0] = 1'b1; repeat (10) step(); sw[0] = 1'b0;
        repeat (8) step();
        chk("tog_off", obs(), 6'b00_0000);

        // Bounce: short press and short low glitch while held.
        sw[1] = 1'b1; repeat (3) step(); sw[1] = 1'b0;
        repeat (20) step();
        chk("bounce_short", obs(), 6'b00_0000);
        sw[1] = 1'b1; repeat (12) step(); sw[1] = 1'b0; repeat (3) step(); sw[1] = 1'b1;
        repeat (20) step();
        chk("bounce_glitch", obs(), 6'b00_0000);
        sw[1] = 1'b0; repeat (8) step();
        chk("tog_led2", obs(), 6'b00_0010);

        // Chase entry and stepping with wrap.
        sw[3] = 1'b1; repeat (10) step(); sw[3] = 1'b0;
        repeat (8) step();
        chk("chase_entry", obs(), 6'b01_0001);
        repeat (7) step();
        chk("chase_dwell", obs(), 6'b01_0001);
        step();
        chk("chase_s1", obs(), 6'b01_0010);
        repeat (8) step();
        chk("chase_s2", obs(), 6'b01_0100);
        repeat (8) step();
        chk("chase_s3", obs(), 6'b01_1000);
        repeat (8) step();
        chk("chase_wrap", obs(), 6'b01_0001);

        // Hold at 0100, reverse while held, resume from frozen tick count.
        repeat (8) step();
        sw[0] = 1'b1; repeat (4) step(); sw[0] = 1'b0; repeat (8) step();
        chk("hold_entry", obs(), 6'b10_0100);
        repeat (30) step();
        chk("hold_frozen", obs(), 6'b10_0100);
        sw[1] = 1'b1; repeat (4) step(); sw[1] = 1'b0; repeat (8) step();
        chk("hold_reverse", obs(), 6'b10_0100);
        sw[0] = 1'b1; repeat (4) step(); sw[0] = 1'b0; repeat (8) step();
        chk("resume", obs(), 6'b01_0100);
        repeat (3) step();
        chk("resume_dwell", obs(), 6'b01_0100);
        step();
        chk("rev_step1", obs(), 6'b01_0010);
        repeat (8) step();
        chk("rev_step2", obs(), 6'b01_0001);

        // Leave chase, then sw1+sw4 released together in TOGGLE.
        sw[3] = 1'b1; repeat (4) step(); sw[3] = 1'b0; repeat (8) step();
        chk("exit_chase", obs(), 6'b00_0000);
        sw = 4'b1001; repeat (10) step(); sw = 4'b0000;
        repeat (8) step();
        chk("prio_rel4", obs(), 6'b01_0001);

        // Asynchronous reset between clock edges, mid-chase.
        repeat (13) step();
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("async_reset", obs(), 6'b00_0000);
        repeat (2) step();
        #2 rst = 1'b0;

        // Random switch activity: mix of long holds and sub-limit glitches.
        for (int c = 0; c < 4000; c++) begin
            for (int s = 0; s < 4; s++) begin
                if ($urandom_range(0, 5) == 0) sw[s] = ~sw[s];
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
